modport_queue: RTL and testbench
================================

# modport_queue

Single-clock 16-bit flit FIFO used as a router input buffer in the NoC. Flits arrive on `data_i`, tagged valid by their MSB, and are enqueued automatically. The head flit is always presented on `data_o`. The downstream arbiter removes the head by asserting `pop_req_i`.

## Interface
Parameters:
- `WIDTH`, 16: flit width in bits; bit `WIDTH-1` is the valid flag.
- `DEPTH`, 4: number of entries; power of two, ≥2.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: reset, asynchronous and active-low; clears all state immediately on assertion.
- `pop_req_i` input 1: remove head entry at next rising edge.
- `data_i` input WIDTH: incoming flit; enqueued when `data_i[WIDTH-1]`=1.
- `data_o` output WIDTH: head flit; all-zero when queue empty.

## Operation
- Push condition: `data_i[WIDTH-1]`=1 sampled at the rising edge, and the queue not full (or full with a simultaneous pop).
- Pushed word is stored unmodified, including its valid bit.
- Pop condition: `pop_req_i`=1 and the queue not empty. A pop request while empty is ignored; no state change.
- No backpressure port exists. A push while full without a pop is silently dropped, and the contents are unchanged.
- Push and pop in the same cycle:
  - Non-empty, non-full: both take effect; count unchanged.
  - Full: both take effect; the new flit enters the freed slot.
  - Empty: the pop is ignored and the push takes effect. The new flit is not bypassed.
- Storage is a circular buffer with a write pointer, a read pointer and an occupancy count of `$clog2(DEPTH)+1` bits.
- Pointers increment modulo `DEPTH` and wrap from `DEPTH-1` to 0.
- Empty is `count==0`; full is `count==DEPTH`.
- `data_o` = `mem[rd_ptr]` when `count>0`, else 0. It is combinational from registered state only, with no path from `data_i` or `pop_req_i`.

## Timing
- Reset (`rst`=0): `wr_ptr`=0, `rd_ptr`=0, `count`=0, so `data_o`=16'h0000 immediately (asynchronous). The storage array is not reset.
- Pop and push are ignored while `rst`=0. Deassertion is synchronized externally; the first active edge is the first after `rst` rises.
- Push latency: a flit pushed at edge N into an empty queue appears on `data_o` after edge N, stable through cycle N+1.
- Pop: the head is removed at edge N. After edge N, `data_o` shows the next entry, or 0 if the queue is now empty.
- FIFO order is strictly preserved across pointer wrap.
- Reset mid-operation discards all queued flits; `data_o` returns to 0 without waiting for a clock edge.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_W`=16
  - `FLIT_VALID_BIT`=15
  - `typedef logic [FLIT_W-1:0] flit_t`
- The module imports these constants; `WIDTH` defaults to `FLIT_W`.
- Single module with the pointer/count control inline. No sub-module: the storage array is a plain register array, and a separate memory wrapper is not warranted at this depth.

## Test plan
- Reset: hold `rst`=0 with `data_i`=16'h8001 and `pop_req_i`=1 toggling → `data_o`=16'h0000 throughout. Release, drive `data_i`=0 → `data_o` stays 0.
- Ordered fill/drain:
  - Push 16'h8001, 16'h8002, 16'h8003 on consecutive edges → `data_o`=16'h8001 after the first edge.
  - Then pop three times → `data_o` shows 16'h8002, 16'h8003, then 16'h0000.
- Invalid flits: drive `data_i`=16'h7FFF for 5 cycles → nothing enqueued, `data_o`=16'h0000.
- Overflow: push 16'h8010..16'h8014 (5 flits, DEPTH=4) with no pops → the fifth is dropped. Four pops yield 16'h8010..16'h8013, then 0.
- Full simultaneous push/pop:
  - With the queue full of 16'h8010..16'h8013, push 16'h80AA with `pop_req_i`=1 → `data_o`=16'h8011.
  - Subsequent pops yield 16'h8012, 16'h8013, 16'h80AA.
- Wrap and empty corner:
  - Cycle 10 push/pop pairs (16'h8100+i) → each value appears exactly once, in order, across pointer wrap.
  - Pop on an empty queue plus simultaneous push 16'h8055 → `data_o`=16'h8055 after the edge.
- Async reset mid-stream: with 3 entries queued, assert `rst` between edges → `data_o` is 0 before the next edge and stays empty after release.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions: flit width, position of the flit valid flag and the
// flit type used by router buffers.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int FLIT_W         = 16;
    localparam int FLIT_VALID_BIT = 15;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage : noc_pkg

// File: rtl/modport_queue.sv
// -----------------------------------------------------------------------------
// modport_queue
// Router input buffer: single-clock circular FIFO of flits. Any flit whose MSB
// is set is enqueued automatically; the head flit is always presented on
// data_o (all-zero when empty) and is removed by the downstream arbiter with
// pop_req_i. There is no backpressure: a push into a full queue without a
// simultaneous pop is dropped.
//
// Ports:
//   clk        in   1      clock, rising edge active
//   rst        in   1      asynchronous active-low reset
//   pop_req_i  in   1      remove head entry at next rising edge
//   data_i     in   WIDTH  incoming flit, enqueued when data_i[WIDTH-1]=1
//   data_o     out  WIDTH  head flit, 0 when queue empty
// -----------------------------------------------------------------------------
module modport_queue
    import noc_pkg::*;
#(
    parameter int WIDTH = FLIT_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop_req_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam int                 CNT_W    = PTR_W + 1;
    localparam int                 VALID_B  = WIDTH - 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_req_i && !empty;
    // A full queue still accepts a flit when the head leaves in the same cycle.
    assign do_push = data_i[VALID_B] && (!full || do_pop);

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only visible once
    // count covers them, so a write landing during reset is never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Head is driven from registered state only; no path from the inputs.
    assign data_o = empty ? '0 : mem_q[rd_ptr_q];

endmodule : modport_queue

// File: tb/tb_modport_queue.sv
// -----------------------------------------------------------------------------
// tb_modport_queue
// Self-checking bench for modport_queue. A behavioural queue holds the flits
// the FIFO should contain; each cycle the expected head is taken from it and
// compared with data_o shortly after the rising edge.
// -----------------------------------------------------------------------------
module tb_modport_queue;
    import noc_pkg::*;

    localparam int DEPTH = 4;

    logic  clk;
    logic  rst;
    logic  pop_req_i;
    flit_t data_i;
    flit_t data_o;

    flit_t sb [$];
    int    vectors_applied = 0;
    int    miscompares     = 0;

    modport_queue #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .pop_req_i (pop_req_i),
        .data_i    (data_i),
        .data_o    (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input flit_t got, input flit_t exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: data_o=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic flit_t sb_head();
        return (sb.size() > 0) ? sb[0] : flit_t'(0);
    endfunction

    // Drive one cycle of stimulus, advance the model across the edge and
    // compare the head afterwards. Inputs change 1 time unit after an edge.
    task automatic cycle(input flit_t d, input logic p, input string tag);
        bit pop_ok;
        bit push_ok;
        data_i    = d;
        pop_req_i = p;
        pop_ok    = 1'b0;
        push_ok   = 1'b0;
        if (rst) begin
            pop_ok  = p && (sb.size() > 0);
            push_ok = d[FLIT_VALID_BIT] && ((sb.size() < DEPTH) || pop_ok);
        end
        @(posedge clk);
        if (pop_ok)  void'(sb.pop_front());
        if (push_ok) sb.push_back(d);
        #1;
        check(tag, data_o, sb_head());
    endtask

    initial begin
        rst       = 1'b0;
        pop_req_i = 1'b0;
        data_i    = 16'h8001;
        #1;
        check("reset_t0", data_o, 16'h0000);

        // Reset held: valid data and toggling pops must have no effect.
        for (int i = 0; i < 4; i++) cycle(16'h8001, i[0], "reset_hold");
        rst = 1'b1;
        cycle(16'h0000, 1'b0, "post_reset_idle");

        // Ordered fill and drain.
        cycle(16'h8001, 1'b0, "fill_1");
        check("fill_1_const", data_o, 16'h8001);
        cycle(16'h8002, 1'b0, "fill_2");
        cycle(16'h8003, 1'b0, "fill_3");
        cycle(16'h0000, 1'b1, "drain_1");
        check("drain_1_const", data_o, 16'h8002);
        cycle(16'h0000, 1'b1, "drain_2");
        check("drain_2_const", data_o, 16'h8003);
        cycle(16'h0000, 1'b1, "drain_3");
        check("drain_3_const", data_o, 16'h0000);

        // Flits without the valid bit are never enqueued.
        for (int i = 0; i < 5; i++) cycle(16'h7FFF, 1'b0, "invalid_flit");

        // Overflow: fifth flit dropped.
        for (int i = 0; i < 5; i++) cycle(flit_t'(16'h8010 + i), 1'b0, "overflow_push");
        for (int i = 0; i < 4; i++) cycle(16'h0000, 1'b1, "overflow_pop");
        check("overflow_empty", data_o, 16'h0000);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) cycle(flit_t'(16'h8010 + i), 1'b0, "refill");
        cycle(16'h80AA, 1'b1, "full_push_pop");
        check("full_push_pop_const", data_o, 16'h8011);
        cycle(16'h0000, 1'b1, "full_pop_1");
        cycle(16'h0000, 1'b1, "full_pop_2");
        cycle(16'h0000, 1'b1, "full_pop_3");
        check("full_pop_3_const", data_o, 16'h80AA);
        cycle(16'h0000, 1'b1, "full_pop_4");

        // Push/pop pairs across pointer wrap; first pair starts from empty.
        for (int i = 0; i < 10; i++) begin
            cycle(flit_t'(16'h8100 + i), 1'b1, "wrap_pair");
            check("wrap_pair_const", data_o, flit_t'(16'h8100 + i));
        end
        cycle(16'h0000, 1'b1, "wrap_drain");

        // Pop while empty with a simultaneous push: no bypass, push lands.
        cycle(16'h8055, 1'b1, "empty_push_pop");
        check("empty_push_pop_const", data_o, 16'h8055);
        cycle(16'h0000, 1'b1, "empty_push_pop_drain");

        // Asynchronous reset between edges with three entries queued.
        for (int i = 0; i < 3; i++) cycle(flit_t'(16'h8200 + i), 1'b0, "pre_async_fill");
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("async_reset_immediate", data_o, 16'h0000);
        cycle(16'h0000, 1'b0, "async_reset_hold");
        rst = 1'b1;
        cycle(16'h0000, 1'b0, "after_release");
        cycle(16'h0000, 1'b1, "after_release_pop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule : tb_modport_queue
